// File: rtl/pq_pkg.sv
// Shared types for the min-tag priority queue and its consumers.
// The entry struct widths are fixed here; users size their ports to match.
package pq_pkg;

    localparam int unsigned PQ_DATA_WIDTH = 32;
    localparam int unsigned PQ_TAG_WIDTH  = 32;

    typedef struct packed {
        logic [PQ_TAG_WIDTH-1:0]  tag;
        logic [PQ_DATA_WIDTH-1:0] data;
    } pq_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } pq_reader_state_t;

    // Counts must be able to hold DEPTH itself, not just DEPTH-1.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pq_reader_if.sv
// Reader-side bundle: queue dequeue port, result stream and run control/status.
// master = the reader engine, slave = the queue/consumer environment around it.
interface pq_reader_if #(
    parameter int unsigned DATA_WIDTH = pq_pkg::PQ_DATA_WIDTH,
    parameter int unsigned TAG_WIDTH  = pq_pkg::PQ_TAG_WIDTH,
    parameter int unsigned DEPTH      = 8
);
    localparam int unsigned CW = pq_pkg::cnt_width(DEPTH);

    logic                  start_in;
    logic [CW-1:0]         count_in;
    logic                  pq_empty_in;
    logic                  pq_valid_in;
    logic [DATA_WIDTH-1:0] pq_data_in;
    logic [TAG_WIDTH-1:0]  pq_tag_in;
    logic                  pq_deq_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic [TAG_WIDTH-1:0]  tag_out;
    logic                  valid_out;
    logic                  ready_in;
    logic                  last_out;
    logic                  busy_out;
    logic                  done_out;
    logic [CW-1:0]         drained_out;
    logic                  order_err_out;

    modport master (
        input  start_in, count_in,
        input  pq_empty_in, pq_valid_in, pq_data_in, pq_tag_in,
        output pq_deq_out,
        output data_out, tag_out, valid_out, last_out,
        input  ready_in,
        output busy_out, done_out, drained_out, order_err_out
    );

    modport slave (
        output start_in, count_in,
        output pq_empty_in, pq_valid_in, pq_data_in, pq_tag_in,
        input  pq_deq_out,
        input  data_out, tag_out, valid_out, last_out,
        output ready_in,
        input  busy_out, done_out, drained_out, order_err_out
    );

endinterface

// File: rtl/pq_reader_buf.sv
// Small synchronous FIFO of queue entries plus a last flag; head is read from the
// register array so the stream outputs never depend on the incoming queue data.
module pq_reader_buf
    import pq_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2
)(
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       push,
    input  pq_entry_t                  push_entry,
    input  logic                       push_last,
    input  logic                       pop,
    output pq_entry_t                  head_entry,
    output logic                       head_last,
    output logic [$clog2(BUF_DEPTH):0] cnt
);
    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam int unsigned BW = PW + 1;

    pq_entry_t            mem_entry [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] mem_last;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic                 full;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (cnt == BW'(BUF_DEPTH));
    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because BUF_DEPTH is a power of two.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            mem_last <= '0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem_entry[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_entry[wr_ptr] <= push_entry;
                mem_last[wr_ptr]  <= push_last;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + BW'(1);
                2'b01:   cnt <= cnt - BW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head_entry = mem_entry[rd_ptr];
    assign head_last  = mem_last[rd_ptr];

endmodule

// File: rtl/pq_reader.sv
// Drains up to count entries from the min-tag queue in ascending-tag order and
// streams them downstream with last marking and a monotonic-order check.
module pq_reader
    import pq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PQ_DATA_WIDTH,
    parameter int unsigned TAG_WIDTH  = PQ_TAG_WIDTH,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned BUF_DEPTH  = 2
)(
    input  logic        clk_in,
    input  logic        rst_in,
    pq_reader_if.master bus
);
    // state | meaning
    // IDLE  | waiting for start_in; count latched, drained/order_err cleared on start
    // DRAIN | issuing dequeues while count, queue contents and buffer space allow
    // FLUSH | no new dequeues; waiting for the in-flight entry and the buffer to empty
    // DONE  | one-cycle done_out pulse, then back to IDLE
    localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] S_DRAIN = 2'(ST_DRAIN);
    localparam logic [1:0] S_FLUSH = 2'(ST_FLUSH);
    localparam logic [1:0] S_DONE  = 2'(ST_DONE);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned BW = $clog2(BUF_DEPTH) + 1;

    logic [1:0]           state;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        issued;
    logic [CW-1:0]        written;
    logic [CW-1:0]        drained;
    logic                 inflight;
    logic                 order_err;
    logic [TAG_WIDTH-1:0] prev_tag;

    pq_entry_t            push_entry;
    pq_entry_t            head;
    logic                 head_last;
    logic [TAG_WIDTH-1:0] head_tag;
    logic [BW-1:0]        buf_cnt;
    logic [BW:0]          used;
    logic                 push;
    logic                 push_last;
    logic                 pop;
    logic                 deq;

    assign push_entry = '{tag:  PQ_TAG_WIDTH'(bus.pq_tag_in),
                          data: PQ_DATA_WIDTH'(bus.pq_data_in)};
    assign head_tag   = TAG_WIDTH'(head.tag);

    assign pop  = bus.valid_out && bus.ready_in;
    assign push = inflight && bus.pq_valid_in;
    assign push_last = (written == count_q - CW'(1));

    // The pending response already owns a slot, and a slot freed this cycle is reusable.
    assign used = (BW+1)'(buf_cnt) + (BW+1)'(inflight) - (BW+1)'(pop);
    assign deq  = (state == S_DRAIN) && (issued < count_q) && !bus.pq_empty_in
                  && (used < (BW+1)'(BUF_DEPTH));

    pq_reader_buf #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .push       (push),
        .push_entry (push_entry),
        .push_last  (push_last),
        .pop        (pop),
        .head_entry (head),
        .head_last  (head_last),
        .cnt        (buf_cnt)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= S_IDLE;
            count_q   <= '0;
            issued    <= '0;
            written   <= '0;
            drained   <= '0;
            inflight  <= 1'b0;
            order_err <= 1'b0;
            prev_tag  <= '0;
        end else begin
            inflight <= deq;
            if (deq) begin
                issued <= issued + CW'(1);
            end
            if (push) begin
                written <= written + CW'(1);
            end
            if (pop) begin
                drained  <= drained + CW'(1);
                prev_tag <= head_tag;
                if ((drained != '0) && (head_tag < prev_tag)) begin
                    order_err <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (bus.start_in) begin
                        count_q   <= bus.count_in;
                        issued    <= '0;
                        written   <= '0;
                        drained   <= '0;
                        order_err <= 1'b0;
                        state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Queue ran dry before count was reached: finish early.
                    if ((issued == count_q) || (bus.pq_empty_in && !inflight)) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (!inflight && (buf_cnt == '0)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.pq_deq_out    = deq;
    assign bus.valid_out     = (buf_cnt != '0);
    assign bus.data_out      = DATA_WIDTH'(head.data);
    assign bus.tag_out       = head_tag;
    assign bus.last_out      = bus.valid_out && head_last;
    assign bus.busy_out      = (state == S_DRAIN) || (state == S_FLUSH);
    assign bus.done_out      = (state == S_DONE);
    assign bus.drained_out   = drained;
    assign bus.order_err_out = order_err;

endmodule

// File: tb/tb_pq_reader.sv
// Directed bench for pq_reader against a behavioural min-tag queue model.
module tb_pq_reader;
    import pq_pkg::*;

    localparam int DW = 32;
    localparam int TW = 32;
    localparam int DEPTH = 8;
    localparam int BUF_DEPTH = 2;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pq_reader_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) pif ();

    pq_reader #(
        .DATA_WIDTH (DW),
        .TAG_WIDTH  (TW),
        .DEPTH      (DEPTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (pif)
    );

    // ---------------- queue model ----------------
    logic [TW-1:0] qt [0:7];
    int            qn = 0;
    logic          q_valid = 1'b0;
    logic [TW-1:0] q_tag = '0;
    logic          fifo_mode = 1'b0;
    logic          ld_en = 1'b0;
    logic [TW-1:0] ld_tag = '0;
    logic          inj_valid = 1'b0;

    always @(posedge clk) begin
        int k;
        q_valid <= pif.pq_deq_out;
        if (ld_en) begin
            qt[qn] <= ld_tag;
            qn     <= qn + 1;
        end else if (pif.pq_deq_out && qn > 0) begin
            k = 0;
            if (!fifo_mode) begin
                for (int i = 1; i < qn; i++) if (qt[i] < qt[k]) k = i;
            end
            q_tag <= qt[k];
            for (int i = 0; i < 7; i++) if (i >= k) qt[i] <= qt[i+1];
            qn <= qn - 1;
        end
    end

    assign pif.pq_empty_in = (qn == 0);
    assign pif.pq_valid_in = q_valid | inj_valid;
    assign pif.pq_tag_in   = inj_valid ? 32'h55 : q_tag;
    assign pif.pq_data_in  = 32'hD000_0000 | pif.pq_tag_in;

    // ---------------- monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0]   rec_tag  [0:63];
    logic [31:0]   rec_data [0:63];
    logic          rec_last [0:63];
    int            rec_cyc  [0:63];
    int            rec_n = 0;
    int            deq_n = 0;
    int            done_n = 0;
    int            done_cyc = 0;
    logic [CW-1:0] done_drained = '0;
    logic          done_oerr = 1'b0;
    logic          done_busy = 1'b0;

    always @(negedge clk) begin
        if (pif.pq_deq_out) deq_n++;
        if (pif.valid_out && pif.ready_in && rec_n < 64) begin
            rec_tag[rec_n]  = pif.tag_out;
            rec_data[rec_n] = pif.data_out;
            rec_last[rec_n] = pif.last_out;
            rec_cyc[rec_n]  = cyc;
            rec_n++;
        end
        if (pif.done_out) begin
            done_n++;
            done_cyc     = cyc;
            done_drained = pif.drained_out;
            done_oerr    = pif.order_err_out;
            done_busy    = pif.busy_out;
        end
    end

    // ---------------- checking helpers ----------------
    int n_assert = 0;
    int n_fail = 0;
    int t0 = 0;
    int b_rec = 0;
    int b_deq = 0;
    int b_done = 0;
    int exp_a [4] = '{1, 3, 7, 9};

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [TW-1:0] tag);
        ld_tag = tag;
        ld_en  = 1'b1;
        step();
        ld_en  = 1'b0;
    endtask

    task automatic start_run(input logic [CW-1:0] cnt);
        step();
        pif.count_in = cnt;
        pif.start_in = 1'b1;
        t0     = cyc;
        b_rec  = rec_n;
        b_deq  = deq_n;
        b_done = done_n;
        step();
        pif.start_in = 1'b0;
    endtask

    task automatic at_cycle(input int k);
        while (cyc - t0 < k) step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 80 && done_n == b_done; i++) begin
            @(negedge clk);
            #1;
        end
        chk(name, done_n - b_done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        pif.start_in = 1'b0;
        pif.count_in = '0;
        pif.ready_in = 1'b0;

        // reset state
        repeat (3) step();
        @(negedge clk); #1;
        chk("rst busy",    pif.busy_out, 0);
        chk("rst done",    pif.done_out, 0);
        chk("rst valid",   pif.valid_out, 0);
        chk("rst deq",     pif.pq_deq_out, 0);
        chk("rst drained", pif.drained_out, 0);
        chk("rst oerr",    pif.order_err_out, 0);
        chk("rst last",    pif.last_out, 0);
        step();
        rst = 1'b0;

        // basic drain, ready held high
        pif.ready_in = 1'b1;
        load(7); load(3); load(9); load(1);
        start_run(4);
        wait_done("t1 done seen");
        chk("t1 count", rec_n - b_rec, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1 tag",  rec_tag[b_rec+i], exp_a[i]);
            chk("t1 cyc",  rec_cyc[b_rec+i] - t0, 3 + i);
            chk("t1 last", rec_last[b_rec+i], (i == 3) ? 1 : 0);
        end
        chk("t1 data", rec_data[b_rec], 32'hD000_0001);
        chk("t1 done cyc", done_cyc - t0, 8);
        chk("t1 busy at done", done_busy, 0);
        chk("t1 drained", done_drained, 4);
        chk("t1 oerr", done_oerr, 0);
        chk("t1 deq", deq_n - b_deq, 4);

        // downstream stall for cycles 3..10
        pif.ready_in = 1'b0;
        load(7); load(3); load(9); load(1);
        start_run(4);
        at_cycle(10);
        chk("t2 deq stalled", deq_n - b_deq, 2);
        chk("t2 valid held", pif.valid_out, 1);
        chk("t2 tag held", pif.tag_out, 1);
        chk("t2 no xfer", rec_n - b_rec, 0);
        step();
        pif.ready_in = 1'b1;
        wait_done("t2 done seen");
        chk("t2 count", rec_n - b_rec, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t2 tag",  rec_tag[b_rec+i], exp_a[i]);
            chk("t2 cyc",  rec_cyc[b_rec+i] - t0, 11 + i);
            chk("t2 last", rec_last[b_rec+i], (i == 3) ? 1 : 0);
        end
        chk("t2 done cyc", done_cyc - t0, 16);
        chk("t2 drained", done_drained, 4);
        chk("t2 deq", deq_n - b_deq, 4);

        // early termination: 2 queued, count 5
        load(4); load(2);
        start_run(5);
        wait_done("t3 done seen");
        chk("t3 count", rec_n - b_rec, 2);
        chk("t3 tag0", rec_tag[b_rec], 2);
        chk("t3 tag1", rec_tag[b_rec+1], 4);
        chk("t3 last0", rec_last[b_rec], 0);
        chk("t3 last1", rec_last[b_rec+1], 0);
        chk("t3 done cyc", done_cyc - t0, 6);
        chk("t3 drained", done_drained, 2);
        chk("t3 deq", deq_n - b_deq, 2);

        // order error: queue returns 5 then 4
        fifo_mode = 1'b1;
        load(5); load(4);
        start_run(2);
        at_cycle(3);
        chk("t4 oerr before", pif.order_err_out, 0);
        at_cycle(5);
        chk("t4 oerr after", pif.order_err_out, 1);
        wait_done("t4 done seen");
        chk("t4 oerr at done", done_oerr, 1);
        chk("t4 tag1", rec_tag[b_rec+1], 4);
        chk("t4 last1", rec_last[b_rec+1], 1);
        chk("t4 done cyc", done_cyc - t0, 6);
        fifo_mode = 1'b0;

        // count 0, with a start pulse during the run
        load(8);
        @(negedge clk); #1;
        chk("t5 oerr sticky idle", pif.order_err_out, 1);
        start_run(0);
        pif.count_in = 4'd3;
        pif.start_in = 1'b1;
        @(negedge clk); #1;
        chk("t5 oerr cleared", pif.order_err_out, 0);
        chk("t5 busy", pif.busy_out, 1);
        step();
        pif.start_in = 1'b0;
        wait_done("t5 done seen");
        chk("t5 done cyc", done_cyc - t0, 3);
        chk("t5 drained", done_drained, 0);
        at_cycle(8);
        chk("t5 busy after", pif.busy_out, 0);
        chk("t5 single done", done_n - b_done, 1);
        chk("t5 deq", deq_n - b_deq, 0);

        // reset with one entry buffered and one response arriving
        pif.ready_in = 1'b0;
        load(6); load(10);
        start_run(3);
        at_cycle(2);
        step();
        rst = 1'b1;
        @(negedge clk); #1;
        chk("t6 valid pre", pif.valid_out, 1);
        chk("t6 tag pre", pif.tag_out, 6);
        step();
        rst = 1'b0;
        inj_valid = 1'b1;
        @(negedge clk); #1;
        chk("t6 valid", pif.valid_out, 0);
        chk("t6 busy", pif.busy_out, 0);
        chk("t6 done", pif.done_out, 0);
        chk("t6 deq", pif.pq_deq_out, 0);
        chk("t6 drained", pif.drained_out, 0);
        chk("t6 data", pif.data_out, 0);
        chk("t6 tag", pif.tag_out, 0);
        step();
        inj_valid = 1'b0;
        @(negedge clk); #1;
        chk("t6 late valid ignored", pif.valid_out, 0);

        // fresh single-entry run after reset
        pif.ready_in = 1'b1;
        start_run(1);
        wait_done("t7 done seen");
        chk("t7 count", rec_n - b_rec, 1);
        chk("t7 tag", rec_tag[b_rec], 10);
        chk("t7 last", rec_last[b_rec], 1);
        chk("t7 cyc", rec_cyc[b_rec] - t0, 3);
        chk("t7 done cyc", done_cyc - t0, 5);
        chk("t7 drained", done_drained, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pq_reader.md
# pq_reader

Consumer-side engine for the min-tag priority queue. On `start_in` it drains up to `count_in` entries in ascending-tag order, using the queue's dequeue handshake (`deq` → registered `valid` one cycle later). It buffers the results in a small FIFO and presents them to a downstream valid/ready stream, with last-entry marking and a monotonic-order check. It sits between the queue and the result consumer, e.g. a k-smallest / nearest-point readout.

## Interface
- `DATA_WIDTH`, 32, payload width (matches queue data)
- `TAG_WIDTH`, 32, priority tag width (matches queue tag)
- `DEPTH`, 8, queue depth; sets count widths
- `BUF_DEPTH`, 2, output buffer entries (power of 2, ≥2)
- `clk_in` input 1 — single clock
- `rst_in` input 1 — reset; synchronous, active-high
- `start_in` input 1 — begin a drain run; sampled only in IDLE
- `count_in` input $clog2(DEPTH)+1 — entries to drain; latched on start
- `pq_empty_in` input 1 — queue empty flag
- `pq_valid_in` input 1 — queue dequeue result valid (1 cycle after deq)
- `pq_data_in` input DATA_WIDTH — dequeued payload
- `pq_tag_in` input TAG_WIDTH — dequeued tag
- `pq_deq_out` output 1 — dequeue request to queue
- `data_out` output DATA_WIDTH — stream payload
- `tag_out` output TAG_WIDTH — stream tag
- `valid_out` output 1 — stream entry valid
- `ready_in` input 1 — downstream ready
- `last_out` output 1 — current stream entry is the `count_in`-th of the run
- `busy_out` output 1 — run in progress
- `done_out` output 1 — one-cycle pulse at end of run
- `drained_out` output $clog2(DEPTH)+1 — entries delivered this run; held until next start
- `order_err_out` output 1 — sticky; a delivered tag was smaller than its predecessor; cleared on start

## Operation
- Reset: state IDLE; all outputs 0; buffer empty; issued/delivered counters 0; in-flight flag 0.
- FSM states:
  - IDLE: on `start_in`, latch count, clear `drained_out`/`order_err_out`, go to DRAIN.
  - DRAIN: assert `pq_deq_out` when `issued < count`, `!pq_empty_in`, and `buf_cnt + inflight - pop < BUF_DEPTH`; `pop` = downstream handshake this cycle. Each request sets `inflight` for the next cycle. Go to FLUSH when `issued == count`, or when `pq_empty_in && !inflight` (early termination).
  - FLUSH: issue nothing; wait for `!inflight` and an empty buffer; go to DONE.
  - DONE: pulse `done_out` for one cycle; go to IDLE.
- `pq_valid_in` is captured only when `inflight` is set; otherwise ignored.
- Stream handshake: an entry transfers when `valid_out && ready_in`. Once asserted, `data_out`/`tag_out`/`last_out`/`valid_out` hold stable until the transfer.
- `last_out`: set on the entry whose delivered index equals count−1. It is never set on early termination (`drained_out < count` signals the short run).
- Order check: compare each delivered tag (unsigned) against the previous one in the run. The first entry of a run is not checked.
- `count_in == 0`: IDLE→DRAIN→FLUSH→DONE with no dequeue; `drained_out` = 0.
- `start_in` outside IDLE is ignored.
- Reset mid-run: abort immediately; buffered and in-flight entries are discarded.

## Timing
- Start at cycle 0 → `busy_out` high and first `pq_deq_out` possible in cycle 1.
- `pq_valid_in` arrives in cycle 2 and is written to the buffer at that edge; `valid_out` is high from cycle 3. Startup latency is 3 cycles.
- Steady state: with `ready_in` held high, one entry per cycle.
- When the last entry transfers at cycle T: FLUSH is exited at T+1, `done_out` pulses in cycle T+2, and `busy_out` goes low in cycle T+2.
- Buffer full with `ready_in` low: no new dequeue issued, so no overflow. The single in-flight entry is always accounted for in the buffer-space check.

## Structure
- `pq_pkg`: `pq_entry_t` struct {tag, data} and `pq_reader_state_t` enum (IDLE, DRAIN, FLUSH, DONE). The queue and other users import it as well.
- Sub-module `pq_reader_buf`: synchronous FIFO of `pq_entry_t` plus a last bit, `BUF_DEPTH` entries, registered output, count output.

## Test plan
- Queue preloaded with tags {7,3,9,1}, `count_in`=4, `ready_in`=1 → tags 1,3,7,9 on consecutive cycles 3–6, `last_out` with 9, `done_out` in cycle 8, `drained_out`=4, `order_err_out`=0.
- Same preload, `ready_in` low for cycles 3–10 → exactly 2 entries buffered, at most 2 dequeues issued, no loss; remaining entries delivered in order once ready returns.
- 2 entries queued, `count_in`=5 → 2 delivered, `last_out` never asserted, `done_out` pulses, `drained_out`=2.
- Model queue returning tags 5 then 4 → `order_err_out` rises on the second handshake, stays high through DONE, clears on the next start.
- `count_in`=0 → no `pq_deq_out`, `done_out` in cycle 3, `drained_out`=0; `start_in` pulsed during a run → ignored.
- `rst_in` asserted while one entry is buffered and one in flight → next cycle all outputs 0, state IDLE; a late `pq_valid_in` is ignored.
